// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point word format, arbiter state encoding and saturation constant
package fxp_pkg;
    localparam int FXP_N = 16;
    localparam int FXP_R = 8;
    typedef enum logic [1:0] {IDLE, START, RUN, RESP} qdiv_arb_state_t;
    localparam logic [FXP_N-2:0] FXP_MAG_ONES = '1;
endpackage

// File: rtl/qdiv.sv
// qdiv: sequential sign-magnitude fixed-point divider, one quotient bit per enabled cycle
// Ports: i_clk, i_reset_n (async, active-low), i_enable, i_start loads operands,
// i_dividend/i_divisor (N-bit sign-magnitude, Q fractional), o_quotient_out,
// o_complete (registered, held until next start), o_overflow (magnitude exceeded N-1 bits)
module qdiv #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_enable,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);
    localparam int W = N + Q;
    localparam int CW = $clog2(W);
    logic [W-1:0] acc, acc_nxt;
    logic [N-1:0] rem, rem_nxt;
    logic [N:0] t;
    logic [N-2:0] dvs;
    logic [CW-1:0] cnt;
    logic busy, sgn, ge;
    // restoring division: shift the next dividend bit into the partial remainder,
    // subtract when it fits, and shift the quotient bit into the vacated LSB
    always_comb begin
        t = {rem, acc[W-1]};
        ge = t >= {2'b0, dvs};
        rem_nxt = ge ? N'(t - {2'b0, dvs}) : t[N-1:0];
        acc_nxt = {acc[W-2:0], ge};
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
            busy <= 1'b0;
            sgn <= 1'b0;
            o_quotient_out <= '0;
            o_complete <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_enable) begin
            if (i_start) begin
                acc <= {1'b0, i_dividend[N-2:0], {Q{1'b0}}};
                rem <= '0;
                dvs <= i_divisor[N-2:0];
                sgn <= i_dividend[N-1] ^ i_divisor[N-1];
                cnt <= CW'(W - 1);
                busy <= 1'b1;
                o_complete <= 1'b0;
            end else if (busy) begin
                acc <= acc_nxt;
                rem <= rem_nxt;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    o_complete <= 1'b1;
                    o_quotient_out <= {sgn, acc_nxt[N-2:0]};
                    o_overflow <= |acc_nxt[W-1:N-1];
                end
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: first active request at or after i_ptr (wrapping), as one-hot and index
// Ports: i_req request vector, i_ptr priority start, o_gnt one-hot grant, o_idx encoded grant
module rr_arbiter_onehot #(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx
);
    // scan from farthest to nearest so the nearest active request wins last
    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(i_ptr) + i) % N_REQ;
            if (i_req[j]) begin
                o_gnt = '0;
                o_gnt[j] = 1'b1;
                o_idx = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/qdiv_arbiter.sv
// qdiv_arbiter: round-robin sharing of one sequential qdiv among N_REQ requesters
// Ports: i_clk, i_reset_n (async, active-low); i_req_valid/i_req_dividend/i_req_divisor
// packed per requester at [k*N +: N], o_req_ready one-hot accept strobe; response channel
// o_rsp_valid/o_rsp_id/o_rsp_quotient/o_rsp_overflow with i_rsp_ready; o_busy when not IDLE.
// Define QDIV_ARBITER_DIVZERO_EN to answer zero-magnitude divisors directly with a
// saturated quotient and overflow, without starting the divider.
module qdiv_arbiter
    import fxp_pkg::*;
#(
    parameter int N = FXP_N,
    parameter int Q = FXP_R,
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*N-1:0] i_req_dividend,
    input  logic [N_REQ*N-1:0] i_req_divisor,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_rsp_valid,
    output logic [ID_W-1:0]    o_rsp_id,
    output logic [N-1:0]       o_rsp_quotient,
    output logic               o_rsp_overflow,
    input  logic               i_rsp_ready,
    output logic               o_busy
);
    qdiv_arb_state_t state;
    logic [ID_W-1:0] ptr, gidx;
    logic [N_REQ-1:0] gnt;
    logic [N-1:0] op_a, op_b, sel_a, sel_b, q_quot;
    logic start, q_done, q_ovf;
    rr_arbiter_onehot #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .i_req(i_req_valid),
        .i_ptr(ptr),
        .o_gnt(gnt),
        .o_idx(gidx)
    );
    qdiv #(.Q(Q), .N(N)) u_div (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_enable(1'b1),
        .i_start(start),
        .i_dividend(op_a),
        .i_divisor(op_b),
        .o_quotient_out(q_quot),
        .o_complete(q_done),
        .o_overflow(q_ovf)
    );
    assign sel_a = i_req_dividend[int'(gidx)*N +: N];
    assign sel_b = i_req_divisor[int'(gidx)*N +: N];
    assign o_req_ready = (state == IDLE) ? gnt : '0;
    assign o_busy = state != IDLE;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            ptr <= '0;
            start <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id <= '0;
            o_rsp_quotient <= '0;
            o_rsp_overflow <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: if (|i_req_valid) begin
                    op_a <= sel_a;
                    op_b <= sel_b;
                    o_rsp_id <= gidx;
                    ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
`ifdef QDIV_ARBITER_DIVZERO_EN
                    if (sel_b[N-2:0] == '0) begin
                        o_rsp_quotient <= {sel_a[N-1] ^ sel_b[N-1], (N-1)'(FXP_MAG_ONES)};
                        o_rsp_overflow <= 1'b1;
                        o_rsp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        start <= 1'b1;
                        state <= START;
                    end
`else
                    start <= 1'b1;
                    state <= START;
`endif
                end
                START: state <= RUN;
                RUN: if (q_done) begin
                    o_rsp_quotient <= q_quot;
                    o_rsp_overflow <= q_ovf;
                    o_rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (i_rsp_ready) begin
                    o_rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
